// File: rtl/sec_csa_acc_pkg.sv
// Shared definitions for the masked carry-save accumulator: FSM states,
// share-slice helpers and the per-share shift-by-one used on the carry vector.
package sec_csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMP = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Low bit index of share i in a vector of k-bit shares.
  function automatic int share_lo(input int i, input int k);
    return i * k;
  endfunction

  // Randomness word used for the ordered share pair (i, j), i != j.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * (n - 1) + ((j < i) ? j : j - 1);
  endfunction

  // One bit of a per-share left shift: each share's LSB takes 0, and the
  // bit below the share boundary (the previous share's MSB) is dropped.
  function automatic logic shl1_bit(input int idx, input int k, input logic lower);
    return ((idx % k) == 0) ? 1'b0 : lower;
  endfunction

endpackage

// File: rtl/sec_csa_acc_secand.sv
// SecAND masked AND gadget with one cycle of latency.
// Every cross-domain product is re-randomised and registered before share compression.
module sec_csa_acc_secand
  import sec_csa_acc_pkg::*;
#(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int RANDNUM   = N_SHARES * (N_SHARES - 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MASKWIDTH-1:0]         a,
  input  logic [MASKWIDTH-1:0]         b,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
  output logic [MASKWIDTH-1:0]         q
);

  logic [K_WIDTH-1:0] term_d [N_SHARES][N_SHARES];
  logic [K_WIDTH-1:0] term_q [N_SHARES][N_SHARES];

  // Terms (i,j) and (j,i) carry the same pair of random words, so the
  // randomness cancels in the recombined product but never within one share.
  always_comb begin
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        term_d[i][j] = a[share_lo(i, K_WIDTH) +: K_WIDTH] & b[share_lo(j, K_WIDTH) +: K_WIDTH];
        if (i != j) begin
          term_d[i][j] = term_d[i][j]
                       ^ rnd[pair_idx(i, j, N_SHARES) * K_WIDTH +: K_WIDTH]
                       ^ rnd[pair_idx(j, i, N_SHARES) * K_WIDTH +: K_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SHARES; i++) begin
        for (int j = 0; j < N_SHARES; j++) begin
          term_q[i][j] <= '0;
        end
      end
    end else begin
      term_q <= term_d;
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        q[share_lo(i, K_WIDTH) +: K_WIDTH] = q[share_lo(i, K_WIDTH) +: K_WIDTH] ^ term_q[i][j];
      end
    end
  end

endmodule

// File: rtl/sec_csa_acc.sv
// Boolean-masked carry-save accumulator, one operand per two cycles.
// Optional output share refresh is enabled by defining SEC_CSA_ACC_REFRESH_EN.
module sec_csa_acc
  import sec_csa_acc_pkg::*;
#(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3,
  parameter int MAX_OPS  = 8,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int RANDNUM   = N_SHARES * (N_SHARES - 1),
  localparam int CNT_W     = $clog2(MAX_OPS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MASKWIDTH-1:0]         in_data,
  input  logic                         in_last,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
`ifdef SEC_CSA_ACC_REFRESH_EN
  input  logic [2*K_WIDTH*(N_SHARES-1)-1:0] rnd_ref,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MASKWIDTH-1:0]         out_s,
  output logic [MASKWIDTH-1:0]         out_c,
  output logic [CNT_W-1:0]             out_cnt
);

  state_t state, state_nxt;

  logic [MASKWIDTH-1:0] s_q, c_q, s_nxt, c_nxt;
  logic [MASKWIDTH-1:0] sum_q, s_dly;
  logic [MASKWIDTH-1:0] a_w, t_w, and_q, carry_pre, carry_sh;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt, cnt_inc;
  logic                 last_dly, issue, wait_done;

  assign a_w       = s_q ^ c_q;
  assign t_w       = s_q ^ in_data;
  assign issue     = (state == ST_COMP) && in_valid;
  assign cnt_inc   = cnt_q + 1'b1;
  assign wait_done = last_dly || (cnt_inc == CNT_W'(MAX_OPS));

  // carry = maj(s, c, x) = (s^c)&(s^x) ^ s, with the AND done in the masked domain
  sec_csa_acc_secand #(
    .K_WIDTH  (K_WIDTH),
    .N_SHARES (N_SHARES)
  ) u_secand (
    .clk (clk),
    .rst (rst),
    .a   (a_w),
    .b   (t_w),
    .rnd (rnd),
    .q   (and_q)
  );

  assign carry_pre = s_dly ^ and_q;

  for (genvar b = 0; b < MASKWIDTH; b++) begin : g_shl
    assign carry_sh[b] = shl1_bit(b, K_WIDTH, carry_pre[(b + MASKWIDTH - 1) % MASKWIDTH]);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? ST_DONE : ST_COMP;
      end
      ST_COMP: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = wait_done ? ST_DONE : ST_COMP;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_nxt   = s_q;
    c_nxt   = c_q;
    cnt_nxt = cnt_q;
    if (state == ST_IDLE && in_valid) begin
      s_nxt   = in_data;
      c_nxt   = '0;
      cnt_nxt = CNT_W'(1);
    end else if (state == ST_WAIT) begin
      s_nxt   = sum_q;
      c_nxt   = carry_sh;
      cnt_nxt = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      s_q   <= s_nxt;
      c_q   <= c_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      s_dly    <= '0;
      last_dly <= 1'b0;
    end else if (issue) begin
      sum_q    <= a_w ^ in_data;
      s_dly    <= s_q;
      last_dly <= in_last;
    end
  end

  assign out_cnt = cnt_q;

`ifdef SEC_CSA_ACC_REFRESH_EN
  logic [MASKWIDTH-1:0] ref_s, ref_c, out_s_q, out_c_q;
  logic                 done_entry;

  assign done_entry = (state_nxt == ST_DONE) && (state != ST_DONE);

  // Last share absorbs the XOR of all refresh words so the recombined value is unchanged.
  always_comb begin
    ref_s = '0;
    ref_c = '0;
    for (int j = 0; j < N_SHARES - 1; j++) begin
      ref_s[share_lo(j, K_WIDTH) +: K_WIDTH] = rnd_ref[share_lo(j, K_WIDTH) +: K_WIDTH];
      ref_c[share_lo(j, K_WIDTH) +: K_WIDTH] = rnd_ref[share_lo(j + N_SHARES - 1, K_WIDTH) +: K_WIDTH];
      ref_s[share_lo(N_SHARES - 1, K_WIDTH) +: K_WIDTH] = ref_s[share_lo(N_SHARES - 1, K_WIDTH) +: K_WIDTH]
                                                        ^ rnd_ref[share_lo(j, K_WIDTH) +: K_WIDTH];
      ref_c[share_lo(N_SHARES - 1, K_WIDTH) +: K_WIDTH] = ref_c[share_lo(N_SHARES - 1, K_WIDTH) +: K_WIDTH]
                                                        ^ rnd_ref[share_lo(j + N_SHARES - 1, K_WIDTH) +: K_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_s_q <= '0;
      out_c_q <= '0;
    end else if (done_entry) begin
      out_s_q <= s_nxt ^ ref_s;
      out_c_q <= c_nxt ^ ref_c;
    end
  end

  assign out_s = out_s_q;
  assign out_c = out_c_q;
`else
  assign out_s = s_q;
  assign out_c = c_q;
`endif

endmodule

// File: tb/tb_sec_csa_acc.sv
// Self-checking bench for sec_csa_acc (K=8, N=3, MAX_OPS=4) against a modular-sum model.
// Refresh scenario is exercised when SEC_CSA_ACC_REFRESH_EN is defined.
module tb_sec_csa_acc;
  localparam int K  = 8;
  localparam int N  = 3;
  localparam int MO = 4;
  localparam int MW = K * N;
  localparam int RW = K * N * (N - 1);
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready;
  logic [MW-1:0] in_data, out_s, out_c;
  logic [RW-1:0] rnd;
  logic [CW-1:0] out_cnt;
`ifdef SEC_CSA_ACC_REFRESH_EN
  logic [2*K*(N-1)-1:0] rnd_ref;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  sec_csa_acc #(.K_WIDTH(K), .N_SHARES(N), .MAX_OPS(MO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .rnd       (rnd),
`ifdef SEC_CSA_ACC_REFRESH_EN
    .rnd_ref   (rnd_ref),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mask_val(input logic [7:0] v);
    logic [7:0] r0, r1;
    r0 = 8'($urandom);
    r1 = 8'($urandom);
    return {v ^ r0 ^ r1, r1, r0};
  endfunction

  function automatic logic [7:0] recomb(input logic [MW-1:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16];
  endfunction

  function automatic logic [RW-1:0] rand_rnd();
    return RW'({$urandom, $urandom});
  endfunction

  // Offer one operand (called at a negedge) and hold it until accepted.
  task automatic send(input logic [MW-1:0] d, input logic last, input logic [RW-1:0] r);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    rnd      = r;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20) begin
      n_fail++;
      $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_cnt, out_s, out_c} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b cnt=%0d s=%h c=%h, required all zero",
               out_valid, out_cnt, out_s, out_c);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_three_ops();
    send(mask_val(8'd3), 1'b0, rand_rnd());
    send(mask_val(8'd5), 1'b0, rand_rnd());
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_in_ready: got %b, required 0", in_ready);
    end
    send(mask_val(8'd7), 1'b1, rand_rnd());
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL three_early_valid: got %b, required 0 during WAIT", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL three_latency: out_valid=%b one cycle after WAIT, required 1", out_valid);
    end
    n_cmp++;
    if (8'(recomb(out_s) + recomb(out_c)) !== 8'd15 || out_cnt !== CW'(3)) begin
      n_fail++;
      $display("FAIL three_sum: sum=%0d cnt=%0d, required 15 / 3",
               8'(recomb(out_s) + recomb(out_c)), out_cnt);
    end
    release_out();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL three_release: valid=%b ready=%b, required 0 / 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    send(mask_val(8'hA5), 1'b1, rand_rnd());
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: out_valid=%b, required 1 next cycle", out_valid);
    end
    n_cmp++;
    if (recomb(out_s) !== 8'hA5 || recomb(out_c) !== 8'h00 || out_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_value: s=%h c=%h cnt=%0d, required a5 / 00 / 1",
               recomb(out_s), recomb(out_c), out_cnt);
    end
    release_out();
  endtask

  task automatic test_max_ops();
    for (int i = 0; i < MO; i++) send(mask_val(8'hFF), 1'b0, rand_rnd());
    wait_out();
    n_cmp++;
    if (8'(recomb(out_s) + recomb(out_c)) !== 8'hFC || out_cnt !== CW'(MO)) begin
      n_fail++;
      $display("FAIL max_ops: sum=%h cnt=%0d, required fc / %0d",
               8'(recomb(out_s) + recomb(out_c)), out_cnt, MO);
    end
    release_out();
  endtask

  task automatic test_hold();
    logic [MW-1:0]  hs, hc;
    logic [CW-1:0]  hn;
    send(mask_val(8'd9), 1'b0, rand_rnd());
    send(mask_val(8'd4), 1'b1, rand_rnd());
    wait_out();
    hs = out_s;
    hc = out_c;
    hn = out_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = MW'($urandom);
      in_last  = 1'($urandom);
      rnd      = rand_rnd();
      @(negedge clk);
      n_cmp++;
      if (out_s !== hs || out_c !== hc || out_cnt !== hn || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: s=%h c=%h cnt=%0d ready=%b valid=%b, required s=%h c=%h cnt=%0d ready=0 valid=1",
                 i, out_s, out_c, out_cnt, in_ready, out_valid, hs, hc, hn);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (8'(recomb(out_s) + recomb(out_c)) !== 8'd13) begin
      n_fail++;
      $display("FAIL hold_sum: got %0d, required 13", 8'(recomb(out_s) + recomb(out_c)));
    end
    release_out();
    send(mask_val(8'h11), 1'b1, rand_rnd());
    n_cmp++;
    if (recomb(out_s) !== 8'h11 || recomb(out_c) !== 8'h00 || out_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL hold_after: s=%h c=%h cnt=%0d, required 11 / 00 / 1",
               recomb(out_s), recomb(out_c), out_cnt);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    send(mask_val(8'd1), 1'b0, rand_rnd());
    send(mask_val(8'd1), 1'b0, rand_rnd());
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_cnt, out_s, out_c} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b cnt=%0d s=%h c=%h ready=%b, required zeros / ready=1",
               out_valid, out_cnt, out_s, out_c, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: out_valid=%b, required 0", out_valid);
    end
    send(mask_val(8'd1), 1'b0, rand_rnd());
    send(mask_val(8'd1), 1'b1, rand_rnd());
    wait_out();
    n_cmp++;
    if (8'(recomb(out_s) + recomb(out_c)) !== 8'd2 || out_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL reset_mid_sum: sum=%0d cnt=%0d, required 2 / 2",
               8'(recomb(out_s) + recomb(out_c)), out_cnt);
    end
    release_out();
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int          n, taken, exp_sum;
      logic [7:0]  v;
      n       = $urandom_range(1, 6);
      taken   = (n < MO) ? n : MO;
      exp_sum = 0;
      for (int k = 0; k < taken; k++) begin
        v = 8'($urandom);
        exp_sum += int'(v);
        send(mask_val(v), (k == n - 1), rand_rnd());
        if (k != taken - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_out();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_cmp++;
      if (8'(recomb(out_s) + recomb(out_c)) !== 8'(exp_sum) || out_cnt !== CW'(taken)) begin
        n_fail++;
        $display("FAIL random_%0d: sum=%h cnt=%0d, required %h / %0d",
                 it, 8'(recomb(out_s) + recomb(out_c)), out_cnt, 8'(exp_sum), taken);
      end
      release_out();
    end
  endtask

`ifdef SEC_CSA_ACC_REFRESH_EN
  task automatic test_refresh();
    logic [MW-1:0] d [3];
    logic [RW-1:0] r [3];
    logic [MW-1:0] s1, c1;
    logic [2*K*(N-1)-1:0] ref_a;
    d[0] = mask_val(8'd40); d[1] = mask_val(8'd77); d[2] = mask_val(8'd200);
    for (int i = 0; i < 3; i++) r[i] = rand_rnd();
    ref_a = 32'($urandom);
    for (int run = 0; run < 2; run++) begin
      rnd_ref = (run == 0) ? ref_a : ref_a ^ 32'h5A3C_9611;
      for (int i = 0; i < 3; i++) send(d[i], (i == 2), r[i]);
      wait_out();
      n_cmp++;
      if (8'(recomb(out_s) + recomb(out_c)) !== 8'(40 + 77 + 200)) begin
        n_fail++;
        $display("FAIL refresh_sum_run%0d: got %h, required %h",
                 run, 8'(recomb(out_s) + recomb(out_c)), 8'(40 + 77 + 200));
      end
      if (run == 0) begin
        s1 = out_s;
        c1 = out_c;
      end else begin
        n_cmp++;
        if (out_s === s1 || out_c === c1) begin
          n_fail++;
          $display("FAIL refresh_shares: run2 s=%h c=%h equal run1 s=%h c=%h, required different",
                   out_s, out_c, s1, c1);
        end
        n_cmp++;
        if (recomb(out_s) !== recomb(s1) || recomb(out_c) !== recomb(c1)) begin
          n_fail++;
          $display("FAIL refresh_recomb: run2 s=%h c=%h, required %h / %h",
                   recomb(out_s), recomb(out_c), recomb(s1), recomb(c1));
        end
      end
      release_out();
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    rnd       = '0;
    out_ready = 1'b0;
`ifdef SEC_CSA_ACC_REFRESH_EN
    rnd_ref   = 32'($urandom);
`endif
    test_reset();
    test_three_ops();
    test_single();
    test_max_ops();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef SEC_CSA_ACC_REFRESH_EN
    test_refresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
